hpm_counter_core: RTL and testbench

Hardware performance monitor slot core on the FPro MMIO bus. It is the responder end of the probe interface that the MCS top drives from the MicroBlaze IO bus strobes (`probe_inst`, `probe_mem_rd`, `probe_mem_wr`). It counts elapsed cycles and probe events, and exposes atomic snapshots of all counters to software through one MMIO slot. It is instantiated inside the MMIO subsystem alongside the switch, LED and UART cores.

---
 rtl/hpm_counter_core.sv | 121 ++++++++++++
 tb/tb_hpm_counter_core.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hpm_counter_core.sv
// Performance monitor MMIO slot: free-running cycle counter plus three probe event counters,
// read by software only through atomic snapshots.
module hpm_counter_core #(
  parameter int unsigned CYC_W = 48,
  parameter int unsigned EVT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        probe_inst,
  input  logic        probe_mem_rd,
  input  logic        probe_mem_wr
);

  logic             en_q, en_d;
  logic [3:0]       ovf_q, ovf_d;
  logic [CYC_W-1:0] cyc_q, cyc_d, snap_cyc_q;
  logic [EVT_W-1:0] inst_q, inst_d, snap_inst_q;
  logic [EVT_W-1:0] rd_q, rd_d, snap_rd_q;
  logic [EVT_W-1:0] wr_q, wr_d, snap_wr_q;

  logic ctrl_wr, clr, snap, cnt_en;
  logic inc_inst, inc_rd, inc_wr;

  // Reads have no side effects, so the strobe and the upper CTRL bits are not needed.
  logic unused_ok;
  assign unused_ok = ^{read, wr_data[31:3]};

  assign ctrl_wr = cs & write & (addr == 5'd0);
  assign clr     = ctrl_wr & wr_data[1];
  assign snap    = ctrl_wr & wr_data[2];

  // Counting needs en both before and after the edge: enabling starts next edge,
  // disabling blocks this edge.
  assign cnt_en   = en_q & en_d;
  assign inc_inst = cnt_en & probe_inst;
  assign inc_rd   = cnt_en & probe_mem_rd;
  assign inc_wr   = cnt_en & probe_mem_wr;

  always_comb begin
    en_d   = ctrl_wr ? wr_data[0] : en_q;
    cyc_d  = cyc_q;
    inst_d = inst_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    ovf_d  = ovf_q;
    if (clr) begin
      cyc_d  = '0;
      inst_d = '0;
      rd_d   = '0;
      wr_d   = '0;
      ovf_d  = '0;
    end else begin
      if (cnt_en) begin
        cyc_d = cyc_q + CYC_W'(1);
        if (&cyc_q) ovf_d[0] = 1'b1;
      end
      if (inc_inst) begin
        inst_d = inst_q + EVT_W'(1);
        if (&inst_q) ovf_d[1] = 1'b1;
      end
      if (inc_rd) begin
        rd_d = rd_q + EVT_W'(1);
        if (&rd_q) ovf_d[2] = 1'b1;
      end
      if (inc_wr) begin
        wr_d = wr_q + EVT_W'(1);
        if (&wr_q) ovf_d[3] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q        <= 1'b0;
      ovf_q       <= '0;
      cyc_q       <= '0;
      inst_q      <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      snap_cyc_q  <= '0;
      snap_inst_q <= '0;
      snap_rd_q   <= '0;
      snap_wr_q   <= '0;
    end else begin
      en_q   <= en_d;
      ovf_q  <= ovf_d;
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      // Snapshots take pre-edge live values, ahead of any clear or increment.
      if (snap) begin
        snap_cyc_q  <= cyc_q;
        snap_inst_q <= inst_q;
        snap_rd_q   <= rd_q;
        snap_wr_q   <= wr_q;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0:    rd_data = {31'd0, en_q};
      5'd1:    rd_data = {28'd0, ovf_q};
      5'd2:    rd_data = snap_cyc_q[31:0];
      5'd3:    rd_data = 32'(snap_cyc_q >> 32);
      5'd4:    rd_data = 32'(snap_inst_q);
      5'd5:    rd_data = 32'(snap_rd_q);
      5'd6:    rd_data = 32'(snap_wr_q);
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_hpm_counter_core.sv
// Self-checking bench for hpm_counter_core: expected read values are queued when a read is
// issued and popped when rd_data is sampled.
module tb_hpm_counter_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        probe_inst, probe_mem_rd, probe_mem_wr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  hpm_counter_core #(
    .CYC_W(48),
    .EVT_W(32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cs          (cs),
    .read        (read),
    .write       (write),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .probe_inst  (probe_inst),
    .probe_mem_rd(probe_mem_rd),
    .probe_mem_wr(probe_mem_wr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    step(1);
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
  endtask

  // One bus cycle: rd_data is sampled mid-cycle, away from the active edge.
  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] got, e;
    exp_q.push_back(exp);
    cs = 1'b1; read = 1'b1; addr = a;
    @(negedge clk);
    got = rd_data;
    e = exp_q.pop_front();
    check_eq(tag, got, e);
    step(1);
    cs = 1'b0; read = 1'b0; addr = '0;
  endtask

  task automatic probes(input logic pi, input logic pr, input logic pw);
    probe_inst = pi; probe_mem_rd = pr; probe_mem_wr = pw;
  endtask

  initial begin
    reset_n = 1'b0;
    cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    probes(1'b0, 1'b0, 1'b0);

    // Reset held 2 cycles with probe activity and a concurrent CTRL write
    cs = 1'b1; write = 1'b1; addr = 5'd0; wr_data = 32'h1;
    for (int i = 0; i < 2; i++) begin
      probes(i[0] == 1'b0, 1'b1, i[0] == 1'b0);
      step(1);
    end
    reset_n = 1'b1;
    cs = 1'b0; write = 1'b0; wr_data = '0;
    probes(1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 7; a++) rd_chk($sformatf("reset_a%0d", a), 5'(a), 32'h0);

    // Basic count: 10 inst, 3 rd, 2 wr, snap taken 101 edges after the enable edge
    bus_wr(5'd0, 32'h1);
    for (int i = 0; i < 10; i++) begin
      probes(1'b1, i < 3, i < 2);
      step(1);
    end
    probes(1'b0, 1'b0, 1'b0);
    step(90);
    bus_wr(5'd0, 32'h5);
    bus_wr(5'd0, 32'h0);
    rd_chk("basic_cyc_lo", 5'd2, 32'd100);
    rd_chk("basic_cyc_hi", 5'd3, 32'd0);
    rd_chk("basic_inst", 5'd4, 32'd10);
    rd_chk("basic_rd", 5'd5, 32'd3);
    rd_chk("basic_wr", 5'd6, 32'd2);
    rd_chk("basic_ctrl", 5'd0, 32'd0);

    // Disabled: probes ignored; cycle count gained one at the CTRL=0x5 edge
    probes(1'b1, 1'b1, 1'b1);
    step(20);
    probes(1'b0, 1'b0, 1'b0);
    bus_wr(5'd0, 32'h4);
    rd_chk("hold_cyc_lo", 5'd2, 32'd101);
    rd_chk("hold_inst", 5'd4, 32'd10);
    rd_chk("hold_rd", 5'd5, 32'd3);
    rd_chk("hold_wr", 5'd6, 32'd2);

    // Clear + snap with coincident probe; enable edge itself does not count
    bus_wr(5'd0, 32'h1);
    probe_inst = 1'b1;
    bus_wr(5'd0, 32'h7);
    probe_inst = 1'b0;
    rd_chk("clrsnap_inst", 5'd4, 32'd10);
    bus_wr(5'd0, 32'h4);
    rd_chk("clrsnap_cyc_lo", 5'd2, 32'd1);
    rd_chk("clrsnap_inst2", 5'd4, 32'd0);
    rd_chk("clrsnap_status", 5'd1, 32'd0);

    // Inst counter wrap sets sticky STATUS bit1
    force dut.inst_q = 32'hFFFF_FFFF;
    #1;
    release dut.inst_q;
    bus_wr(5'd0, 32'h1);
    probe_inst = 1'b1;
    step(1);
    probe_inst = 1'b0;
    bus_wr(5'd0, 32'h4);
    rd_chk("ovf_inst", 5'd4, 32'd0);
    rd_chk("ovf_status", 5'd1, 32'h2);
    step(3);
    rd_chk("ovf_sticky", 5'd1, 32'h2);
    bus_wr(5'd0, 32'h0);
    rd_chk("ovf_sticky_nclr", 5'd1, 32'h2);
    bus_wr(5'd0, 32'h2);
    rd_chk("ovf_cleared", 5'd1, 32'h0);
    rd_chk("ctrl_after_clr", 5'd0, 32'h0);

    // Cycle counter carry across 2^32
    force dut.cyc_q = 48'h0000_FFFF_FFFE;
    #1;
    release dut.cyc_q;
    bus_wr(5'd0, 32'h1);
    step(5);
    bus_wr(5'd0, 32'h4);
    rd_chk("carry_cyc_lo", 5'd2, 32'd3);
    rd_chk("carry_cyc_hi", 5'd3, 32'd1);
    rd_chk("carry_status", 5'd1, 32'h0);

    // en bit readback, then reset mid-operation beats a concurrent write
    bus_wr(5'd0, 32'h7);
    rd_chk("ctrl_en", 5'd0, 32'h1);
    probes(1'b1, 1'b1, 1'b1);
    step(4);
    reset_n = 1'b0;
    bus_wr(5'd0, 32'h5);
    reset_n = 1'b1;
    probes(1'b0, 1'b0, 1'b0);
    rd_chk("rst2_ctrl", 5'd0, 32'h0);
    rd_chk("rst2_cyc_lo", 5'd2, 32'h0);
    rd_chk("rst2_inst", 5'd4, 32'h0);

    // Writes outside CTRL ignored, unmapped addresses read 0
    bus_wr(5'd2, 32'hDEAD_BEEF);
    bus_wr(5'd1, 32'hF);
    rd_chk("ro_snap_lo", 5'd2, 32'h0);
    rd_chk("ro_status", 5'd1, 32'h0);
    bus_wr(5'd0, 32'h1);
    rd_chk("unmapped_7", 5'd7, 32'h0);
    rd_chk("unmapped_31", 5'd31, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
